// File: rtl/arcade_ioctl_router.sv
// Loader front-end for arcade cores: routes the hps_io ROM byte stream into NREG target
// regions with per-target back-pressure, captures DIP/mod bytes and sequences core reset.
module arcade_ioctl_router #(
    parameter int unsigned         NREG        = 4,
    parameter int unsigned         LAW         = 16,
    parameter logic [NREG*25-1:0]  REG_BASE    = '0,
    parameter logic [NREG*25-1:0]  REG_SIZE    = '0,
    parameter int unsigned         DIP_BYTES   = 8,
    parameter logic [7:0]          ROM_INDEX   = 8'd0,
    parameter logic [7:0]          MOD_INDEX   = 8'd1,
    parameter logic [7:0]          DIP_INDEX   = 8'd254,
    parameter int unsigned         HOLD_CYCLES = 16
) (
    input  logic                     clk_sys,
    input  logic                     RESET_n,
    input  logic                     ioctl_download,
    input  logic                     ioctl_wr,
    input  logic [24:0]              ioctl_addr,
    input  logic [7:0]               ioctl_dout,
    input  logic [7:0]               ioctl_index,
    output logic                     ioctl_wait,
    input  logic [NREG-1:0]          tgt_ready,
    output logic [NREG-1:0]          tgt_wr,
    output logic [LAW-1:0]           tgt_addr,
    output logic [7:0]               tgt_data,
    output logic [8*DIP_BYTES-1:0]   dip_flat,
    output logic [7:0]               mod_sel,
    output logic                     core_reset_n,
    output logic                     rom_loaded,
    output logic                     err_unmapped,
    output logic                     err_overrun
);
    localparam int unsigned RW = (NREG > 1) ? $clog2(NREG) : 1;
    localparam int unsigned CW = $clog2(HOLD_CYCLES + 1);

    for (genvar g = 0; g < NREG; g++) begin : g_size_check
        if (64'(REG_SIZE[g*25 +: 25]) > (64'd1 << LAW)) begin : g_bad_size
            $error("region %0d is larger than the local address space", g);
        end
    end

    typedef enum logic [1:0] {StIdle, StPend, StHold} state_t;

    state_t                 state_q, state_d;
    logic [RW-1:0]          reg_q, reg_d;
    logic [LAW-1:0]         addr_q, addr_d;
    logic [7:0]             data_q, data_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   run_q, run_d;
    logic                   unmapped_q, overrun_q;
    logic [8*DIP_BYTES-1:0] dip_q;
    logic [7:0]             mod_q;
    logic                   dl_q, rom_active_q, mapped_q, loaded_q;

    logic                   hit;
    logic [RW-1:0]          hit_idx;
    logic [LAW-1:0]         hit_off;
    logic                   rom_wr, ready_sel, strobe;

    assign rom_wr    = ioctl_wr && ioctl_download && (ioctl_index == ROM_INDEX);
    assign ready_sel = tgt_ready[reg_q];
    assign strobe    = (state_q == StPend) && ready_sel;

    // Descending scan so the lowest matching region overrides higher ones.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        hit_off = '0;
        for (int i = int'(NREG) - 1; i >= 0; i--) begin
            if (REG_SIZE[i*25 +: 25] != 25'd0 && ioctl_addr >= REG_BASE[i*25 +: 25] &&
                {1'b0, ioctl_addr} < {1'b0, REG_BASE[i*25 +: 25]} + {1'b0, REG_SIZE[i*25 +: 25]})
            begin
                hit     = 1'b1;
                hit_idx = RW'(i);
                hit_off = LAW'(ioctl_addr - REG_BASE[i*25 +: 25]);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        reg_d   = reg_q;
        addr_d  = addr_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        run_d   = run_q && !ioctl_download;
        case (state_q)
            StPend: begin
                if (ready_sel) state_d = StIdle;
            end
            default: begin
                if (rom_wr && hit) begin
                    reg_d   = hit_idx;
                    addr_d  = hit_off;
                    data_d  = ioctl_dout;
                    state_d = StPend;
                end else if (ioctl_download) begin
                    state_d = StIdle;
                end else if (state_q == StHold) begin
                    if (cnt_q <= CW'(1)) begin
                        run_d   = 1'b1;
                        state_d = StIdle;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end else if (!run_q) begin
                    if (HOLD_CYCLES <= 1) begin
                        run_d = 1'b1;
                    end else begin
                        state_d = StHold;
                        cnt_d   = CW'(HOLD_CYCLES - 1);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_sys or negedge RESET_n) begin
        if (!RESET_n) begin
            state_q      <= StIdle;
            reg_q        <= '0;
            addr_q       <= '0;
            data_q       <= '0;
            cnt_q        <= '0;
            run_q        <= 1'b0;
            unmapped_q   <= 1'b0;
            overrun_q    <= 1'b0;
            dip_q        <= '0;
            mod_q        <= '0;
            dl_q         <= 1'b0;
            rom_active_q <= 1'b0;
            mapped_q     <= 1'b0;
            loaded_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            reg_q   <= reg_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            run_q   <= run_d;
            dl_q    <= ioctl_download;
            if (rom_wr && state_q != StPend && !hit) unmapped_q <= 1'b1;
            if (ioctl_wr && state_q == StPend) overrun_q <= 1'b1;
            if (ioctl_wr && ioctl_index == DIP_INDEX) begin
                for (int k = 0; k < int'(DIP_BYTES); k++) begin
                    if (ioctl_addr == 25'(k)) dip_q[k*8 +: 8] <= ioctl_dout;
                end
            end
            if (ioctl_wr && ioctl_index == MOD_INDEX) mod_q <= ioctl_dout;
            // Load status settles only once the last pending byte has been strobed out.
            if (ioctl_download && !dl_q && ioctl_index == ROM_INDEX) begin
                rom_active_q <= 1'b1;
                mapped_q     <= 1'b0;
                loaded_q     <= 1'b0;
            end else if (rom_active_q && !ioctl_download && state_q != StPend) begin
                rom_active_q <= 1'b0;
                loaded_q     <= mapped_q;
            end
            if (strobe) mapped_q <= 1'b1;
        end
    end

    always_comb begin
        tgt_wr = '0;
        if (strobe) tgt_wr[reg_q] = 1'b1;
    end

    assign ioctl_wait   = (state_q == StPend) && !ready_sel;
    assign tgt_addr     = addr_q;
    assign tgt_data     = data_q;
    assign dip_flat     = dip_q;
    assign mod_sel      = mod_q;
    assign core_reset_n = run_q && !ioctl_download && (state_q != StPend);
    assign rom_loaded   = loaded_q;
    assign err_unmapped = unmapped_q;
    assign err_overrun  = overrun_q;

endmodule

// File: tb/tb_arcade_ioctl_router.sv
// Randomized self-checking bench for arcade_ioctl_router with a two-region map,
// an address-range reference model and sticky-flag / DIP / mod shadow state.
module tb_arcade_ioctl_router;
    localparam logic [7:0] ROM_IDX = 8'd0;
    localparam logic [7:0] MOD_IDX = 8'd1;
    localparam logic [7:0] DIP_IDX = 8'd254;
    localparam int         HOLD    = 16;

    logic        clk_sys, RESET_n;
    logic        ioctl_download, ioctl_wr, ioctl_wait;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout, ioctl_index;
    logic [1:0]  tgt_ready, tgt_wr;
    logic [15:0] tgt_addr;
    logic [7:0]  tgt_data, mod_sel;
    logic [63:0] dip_flat;
    logic        core_reset_n, rom_loaded, err_unmapped, err_overrun;

    arcade_ioctl_router #(
        .NREG(2), .LAW(16),
        .REG_BASE({25'h08000, 25'h00000}),
        .REG_SIZE({25'h04000, 25'h08000}),
        .DIP_BYTES(8), .ROM_INDEX(ROM_IDX), .MOD_INDEX(MOD_IDX), .DIP_INDEX(DIP_IDX),
        .HOLD_CYCLES(HOLD)
    ) dut (
        .clk_sys(clk_sys), .RESET_n(RESET_n), .ioctl_download(ioctl_download),
        .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .ioctl_index(ioctl_index), .ioctl_wait(ioctl_wait), .tgt_ready(tgt_ready),
        .tgt_wr(tgt_wr), .tgt_addr(tgt_addr), .tgt_data(tgt_data), .dip_flat(dip_flat),
        .mod_sel(mod_sel), .core_reset_n(core_reset_n), .rom_loaded(rom_loaded),
        .err_unmapped(err_unmapped), .err_overrun(err_overrun)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    int unsigned m_base [2] = '{32'h0000, 32'h8000};
    int unsigned m_size [2] = '{32'h8000, 32'h4000};
    int          n_checks = 0;
    int          n_pass   = 0;
    bit          exp_unmapped, exp_overrun, exp_mapped;
    logic [7:0]  exp_dip [8];
    logic [7:0]  exp_mod;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    function automatic void model_decode(input int unsigned a, output bit h, output int r,
                                         output int unsigned off);
        h = 1'b0; r = 0; off = 0;
        for (int i = 0; i < 2; i++) begin
            if (!h && m_size[i] != 0 && a >= m_base[i] && a < m_base[i] + m_size[i]) begin
                h = 1'b1; r = i; off = (a - m_base[i]) & 32'hFFFF;
            end
        end
    endfunction

    task automatic check_reset_vals(input string tag);
        check({tag, "_wr"}, tgt_wr, 0);
        check({tag, "_wait"}, ioctl_wait, 0);
        check({tag, "_addr"}, tgt_addr, 0);
        check({tag, "_data"}, tgt_data, 0);
        check({tag, "_dip"}, dip_flat, 0);
        check({tag, "_mod"}, mod_sel, 0);
        check({tag, "_core"}, core_reset_n, 0);
        check({tag, "_loaded"}, rom_loaded, 0);
        check({tag, "_unmap"}, err_unmapped, 0);
        check({tag, "_ovr"}, err_overrun, 0);
    endtask

    task automatic check_dip();
        logic [63:0] f;
        for (int k = 0; k < 8; k++) f[k*8 +: 8] = exp_dip[k];
        check("dip_flat", dip_flat, f);
    endtask

    task automatic rom_byte(input int unsigned a, input logic [7:0] d, input int stall,
                            input bit inject);
        bit h; int r; int unsigned off;
        model_decode(a, h, r, off);
        ioctl_wr = 1'b1; ioctl_addr = 25'(a); ioctl_dout = d; ioctl_index = ROM_IDX;
        tgt_ready = 2'($urandom);
        tick();
        ioctl_wr = 1'b0;
        if (!h) begin
            exp_unmapped = 1'b1;
            settle();
            check("miss_no_wr", tgt_wr, 0);
            check("miss_no_wait", ioctl_wait, 0);
            check("err_unmapped", err_unmapped, 1);
            return;
        end
        for (int k = 0; k < stall; k++) begin
            tgt_ready = 2'($urandom);
            tgt_ready[r] = 1'b0;
            if (inject && k == 0) begin
                ioctl_wr = 1'b1; ioctl_addr = 25'(a + 1); ioctl_dout = ~d;
                exp_overrun = 1'b1;
            end
            settle();
            check("stall_wait", ioctl_wait, 1);
            check("stall_no_wr", tgt_wr, 0);
            tick();
            ioctl_wr = 1'b0;
        end
        tgt_ready = 2'($urandom);
        tgt_ready[r] = 1'b1;
        settle();
        check("strobe_wr", tgt_wr, 64'(1) << r);
        check("strobe_addr", tgt_addr, 64'(off));
        check("strobe_data", tgt_data, d);
        check("strobe_wait", ioctl_wait, 0);
        exp_mapped = 1'b1;
        tick();
        settle();
        check("single_strobe", tgt_wr, 0);
        check("err_overrun", err_overrun, exp_overrun);
    endtask

    task automatic dip_write(input int unsigned a, input logic [7:0] d);
        ioctl_wr = 1'b1; ioctl_index = DIP_IDX; ioctl_addr = 25'(a); ioctl_dout = d;
        if (a < 8) exp_dip[a] = d;
        tick();
        ioctl_wr = 1'b0;
    endtask

    task automatic mod_write(input logic [7:0] d);
        ioctl_wr = 1'b1; ioctl_index = MOD_IDX; ioctl_addr = 25'($urandom); ioctl_dout = d;
        exp_mod = d;
        tick();
        ioctl_wr = 1'b0;
        check("mod_sel", mod_sel, exp_mod);
    endtask

    task automatic start_download();
        ioctl_download = 1'b1; ioctl_index = ROM_IDX; exp_mapped = 1'b0;
        tick();
    endtask

    task automatic end_download();
        ioctl_download = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        check("rom_loaded", rom_loaded, exp_mapped);
    endtask

    int unsigned bnd [6] = '{32'h0, 32'h7FFF, 32'h8000, 32'hBFFF, 32'hC000, 32'h1FFFFFF};

    initial begin
        RESET_n = 1'b0; ioctl_download = 1'b0; ioctl_wr = 1'b0; ioctl_addr = '0;
        ioctl_dout = '0; ioctl_index = '0; tgt_ready = 2'b11;
        exp_unmapped = 0; exp_overrun = 0; exp_mapped = 0; exp_mod = '0;
        for (int k = 0; k < 8; k++) exp_dip[k] = '0;
        #12;
        check_reset_vals("reset");
        tick(); tick();
        RESET_n = 1'b1;
        for (int k = 0; k < HOLD + 4; k++) tick();

        // Mapped bytes: region-1 hit with ready, then a stalled region-0 write plus overrun.
        start_download();
        settle();
        check("core_held_dl", core_reset_n, 0);
        rom_byte(32'h8003, 8'hA5, 0, 1'b0);
        rom_byte(32'h0010, 8'h5A, 3, 1'b1);
        end_download();

        // Unmapped-only download clears and then keeps rom_loaded low.
        start_download();
        check("loaded_cleared", rom_loaded, 0);
        rom_byte(32'hC000, 8'h33, 0, 1'b0);
        end_download();

        for (int a = 0; a <= 8; a++) dip_write(a, 8'(8'h10 + a));
        check_dip();
        mod_write(8'h01);

        // Hold release timing after a single mapped byte.
        start_download();
        rom_byte(32'h1234, 8'h77, 1, 1'b0);
        check("core_held", core_reset_n, 0);
        ioctl_download = 1'b0;
        for (int k = 0; k < HOLD - 1; k++) tick();
        check("core_still_held", core_reset_n, 0);
        tick();
        check("core_released", core_reset_n, 1);
        check("loaded_after_hold", rom_loaded, 1);

        // Randomized mix of ROM bytes (with boundary addresses), DIP and mod writes.
        start_download();
        for (int n = 0; n < 80; n++) begin
            int c;
            int unsigned a;
            c = $urandom_range(0, 9);
            if (c == 0) begin
                dip_write($urandom_range(0, 11), 8'($urandom));
                check_dip();
            end else if (c == 1) begin
                mod_write(8'($urandom));
            end else begin
                a = ($urandom_range(0, 3) == 0) ? bnd[$urandom_range(0, 5)]
                                                : $urandom_range(0, 32'hFFFF);
                rom_byte(a, 8'($urandom), $urandom_range(0, 2), 1'b0);
            end
        end
        end_download();
        check("rand_unmapped", err_unmapped, exp_unmapped);
        check("rand_overrun", err_overrun, exp_overrun);

        // Asynchronous reset while a write is pending must drop it silently.
        start_download();
        ioctl_wr = 1'b1; ioctl_addr = 25'h10; ioctl_dout = 8'hC3; ioctl_index = ROM_IDX;
        tgt_ready = 2'b10;
        tick();
        ioctl_wr = 1'b0;
        settle();
        check("pend_wait", ioctl_wait, 1);
        #2;
        RESET_n = 1'b0;
        #1;
        check_reset_vals("async_rst");
        ioctl_download = 1'b0;
        tgt_ready = 2'b11;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("rst_no_wr", tgt_wr, 0);
        end
        RESET_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("post_rst_no_wr", tgt_wr, 0);
            check("post_rst_wait", ioctl_wait, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/arcade_ioctl_router.md
Name: arcade_ioctl_router

Overview:
- Generalised loader front-end between hps_io ioctl download port and an arcade core's ROM/RAM regions.
- Decodes linear ROM stream into NREG parameterised regions with per-target ready handshake; back-pressures HPS via ioctl_wait.
- Captures DIP bytes and mod byte, generates core hold-reset and load-complete status.
- Replaces the ad-hoc DIP/mod capture and download gating in each emu top.

Parameters:
NREG, 4, number of target regions (1..8)
LAW, 16, local address width presented to targets
REG_BASE, {NREG{25'd0}}, packed NREG*25 bits; region i base = REG_BASE[i*25 +: 25]
REG_SIZE, {NREG{25'd0}}, packed NREG*25 bits; region i size in bytes, 0 = disabled
DIP_BYTES, 8, DIP bytes captured (1..8)
ROM_INDEX, 0, ioctl_index value for ROM stream
MOD_INDEX, 1, ioctl_index value for mod byte
DIP_INDEX, 254, ioctl_index value for DIP bytes
HOLD_CYCLES, 16, core reset extension after download ends (>=1)

Ports:
clk_sys  in  1  system clock
RESET_n  in  1  asynchronous active-low reset
ioctl_download  in  1  download active
ioctl_wr  in  1  byte strobe
ioctl_addr  in  25  byte address
ioctl_dout  in  8  byte data
ioctl_index  in  8  stream index
ioctl_wait  out  1  stall request to hps_io
tgt_ready  in  NREG  target i accepts a write this cycle
tgt_wr  out  NREG  one-hot write strobe
tgt_addr  out  LAW  ioctl_addr minus region base, truncated to LAW
tgt_data  out  8  write data
dip_flat  out  8*DIP_BYTES  DIP byte k at [k*8 +: 8]
mod_sel  out  8  last mod byte
core_reset_n  out  1  core run enable
rom_loaded  out  1  ROM stream completed with at least one mapped byte
err_unmapped  out  1  sticky: ROM byte outside all regions
err_overrun  out  1  sticky: ioctl_wr received while ioctl_wait high

Behaviour:
- Reset values: all outputs 0 except tgt_addr/tgt_data 0; dip_flat 0; mod_sel 0; core_reset_n 0. Reset mid-operation aborts any pending write with no strobe issued.
- FSM states IDLE, PEND, HOLD.
- IDLE: on ioctl_wr & ioctl_download & index==ROM_INDEX, decode region: base <= addr < base+size, size!=0; lowest i wins on overlap.
  - Hit: latch addr-base, data, region; go PEND.
  - Miss: set err_unmapped, stay IDLE.
- PEND: tgt_wr[i]=1 in the same cycle tgt_ready[i]=1, then IDLE. Latency from ioctl_wr to strobe is >=1 cycle; exactly 1 cycle when ready.
  - ioctl_wait=1 in every PEND cycle where tgt_ready[i]=0, combinationally from state and ready.
  - ioctl_wr during PEND: sets err_overrun; byte dropped.
- DIP: ioctl_wr & index==DIP_INDEX & addr<DIP_BYTES writes byte addr; higher addresses are ignored. No download gating is applied.
- MOD: ioctl_wr & index==MOD_INDEX updates mod_sel regardless of address.
- core_reset_n: 0 while ioctl_download=1 or FSM in PEND. After both are clear, a HOLD_CYCLES counter counts down, then core_reset_n goes to 1. A new download restarts the hold.
- rom_loaded: cleared on rising edge of ioctl_download with ROM index. Set on falling edge if at least one mapped strobe was issued during that download.
- err_* are cleared only by RESET_n.
- Width rule: offset = addr-base is computed at 25 bits, lower LAW bits output. REG_SIZE > 2^LAW is a parameter error flagged by elaboration assertion.

Test Plan:
- NREG=2, regions {0x0000, size 0x8000} and {0x8000, size 0x4000}, tgt_ready=11, write addr 0x8003 data 0xA5 -> next cycle tgt_wr=2'b10, tgt_addr=0x0003, tgt_data=0xA5, ioctl_wait=0.
- tgt_ready[0]=0 for 3 cycles after write to addr 0x10 -> ioctl_wait high 3 cycles, tgt_wr[0] pulses once on the 4th cycle. An extra ioctl_wr during the stall sets err_overrun=1.
- Write addr 0xC000 (unmapped) -> no tgt_wr, err_unmapped=1. Download end with no mapped bytes -> rom_loaded=0.
- DIP index 254, addrs 0..8 data 0x10..0x18, DIP_BYTES=8 -> dip_flat bytes 0..7 = 0x10..0x17, addr 8 ignored. Mod index 1 data 0x01 -> mod_sel=0x01.
- Download 1 byte mapped, deassert download -> core_reset_n low during download, high exactly HOLD_CYCLES=16 cycles after the drop; rom_loaded=1.
- Assert RESET_n=0 while in PEND -> no tgt_wr ever issued; all outputs return to reset values asynchronously.
